// File: rtl/apb_arbiter.sv
// Round-robin arbiter that serialises two command ports onto one APB3 master bus.
// Each accepted command runs as one setup/access transfer, with an access timeout.
module apb_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       cpu_clk,
    input  logic       cpu_rst,
    input  logic       req0_valid,
    input  logic       req0_write,
    input  logic [7:0] req0_addr,
    input  logic [7:0] req0_wdata,
    output logic       req0_ready,
    output logic       req0_done,
    output logic [7:0] req0_rdata,
    output logic       req0_err,
    input  logic       req1_valid,
    input  logic       req1_write,
    input  logic [7:0] req1_addr,
    input  logic [7:0] req1_wdata,
    output logic       req1_ready,
    output logic       req1_done,
    output logic [7:0] req1_rdata,
    output logic       req1_err,
    output logic       psel,
    output logic       penable,
    output logic       pwrite,
    output logic [7:0] paddr,
    output logic [7:0] pwdata,
    input  logic [7:0] prdata,
    input  logic       pready,
    input  logic       pslverr
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state, state_nxt;
    logic       owner, owner_nxt;
    logic       last_grant, last_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       psel_nxt, penable_nxt, pwrite_nxt;
    logic [7:0] paddr_nxt, pwdata_nxt;
    logic [1:0] ready_q, ready_nxt;
    logic [1:0] done_q, done_nxt;
    logic       err0_nxt, err1_nxt;
    logic [7:0] rdata0_nxt, rdata1_nxt;

    logic       pick;
    logic       sel_write;
    logic [7:0] sel_addr, sel_wdata;
    logic       fin_err, fin_load;
    logic [7:0] fin_rdata;

    // Tie goes to the port that did not finish last; otherwise the lone requester.
    assign pick      = (req0_valid && req1_valid) ? ~last_grant : ~req0_valid;
    assign sel_write = pick ? req1_write : req0_write;
    assign sel_addr  = pick ? req1_addr  : req0_addr;
    assign sel_wdata = pick ? req1_wdata : req0_wdata;

    assign req0_ready = ready_q[0];
    assign req1_ready = ready_q[1];
    assign req0_done  = done_q[0];
    assign req1_done  = done_q[1];

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        last_nxt    = last_grant;
        cnt_nxt     = cnt;
        psel_nxt    = psel;
        penable_nxt = penable;
        pwrite_nxt  = pwrite;
        paddr_nxt   = paddr;
        pwdata_nxt  = pwdata;
        ready_nxt   = 2'b00;
        done_nxt    = 2'b00;
        err0_nxt    = req0_err;
        err1_nxt    = req1_err;
        rdata0_nxt  = req0_rdata;
        rdata1_nxt  = req1_rdata;
        fin_err     = 1'b1;
        fin_load    = 1'b1;
        fin_rdata   = 8'h00;
        unique case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    owner_nxt   = pick;
                    psel_nxt    = 1'b1;
                    penable_nxt = 1'b0;
                    pwrite_nxt  = sel_write;
                    paddr_nxt   = sel_addr;
                    pwdata_nxt  = sel_write ? sel_wdata : 8'h00;
                    ready_nxt   = pick ? 2'b10 : 2'b01;
                    state_nxt   = SETUP;
                end
            end
            SETUP: begin
                penable_nxt = 1'b1;
                cnt_nxt     = 8'h00;
                state_nxt   = ACCESS;
            end
            ACCESS: begin
                if (pready || cnt == CNT_LAST) begin
                    // A late pready on the final wait cycle still completes normally.
                    if (pready) begin
                        fin_err   = pslverr;
                        fin_load  = ~pwrite;
                        fin_rdata = prdata;
                    end
                    psel_nxt    = 1'b0;
                    penable_nxt = 1'b0;
                    pwrite_nxt  = 1'b0;
                    pwdata_nxt  = 8'h00;
                    done_nxt    = owner ? 2'b10 : 2'b01;
                    last_nxt    = owner;
                    state_nxt   = IDLE;
                    if (owner) begin
                        err1_nxt = fin_err;
                        if (fin_load) rdata1_nxt = fin_rdata;
                    end else begin
                        err0_nxt = fin_err;
                        if (fin_load) rdata0_nxt = fin_rdata;
                    end
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= 8'h00;
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            paddr      <= 8'h00;
            pwdata     <= 8'h00;
            ready_q    <= 2'b00;
            done_q     <= 2'b00;
            req0_err   <= 1'b0;
            req1_err   <= 1'b0;
            req0_rdata <= 8'h00;
            req1_rdata <= 8'h00;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_grant <= last_nxt;
            cnt        <= cnt_nxt;
            psel       <= psel_nxt;
            penable    <= penable_nxt;
            pwrite     <= pwrite_nxt;
            paddr      <= paddr_nxt;
            pwdata     <= pwdata_nxt;
            ready_q    <= ready_nxt;
            done_q     <= done_nxt;
            req0_err   <= err0_nxt;
            req1_err   <= err1_nxt;
            req0_rdata <= rdata0_nxt;
            req1_rdata <= rdata1_nxt;
        end
    end

endmodule

// File: tb/tb_apb_arbiter.sv
// Bench for apb_arbiter: directed scenarios plus random traffic against a
// transfer-schedule model of the arbiter and APB bus.
module tb_apb_arbiter;

    localparam int TO = 4;

    logic       cpu_clk = 1'b0;
    logic       cpu_rst;
    logic       req0_valid, req0_write, req1_valid, req1_write;
    logic [7:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
    logic       req0_ready, req0_done, req0_err;
    logic       req1_ready, req1_done, req1_err;
    logic [7:0] req0_rdata, req1_rdata;
    logic       psel, penable, pwrite;
    logic [7:0] paddr, pwdata, prdata;
    logic       pready, pslverr;

    apb_arbiter #(.TIMEOUT(TO)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
        .req0_valid(req0_valid), .req0_write(req0_write),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_ready(req0_ready), .req0_done(req0_done),
        .req0_rdata(req0_rdata), .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_write(req1_write),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_ready(req1_ready), .req1_done(req1_done),
        .req1_rdata(req1_rdata), .req1_err(req1_err),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .pslverr(pslverr)
    );

    always #5 cpu_clk = ~cpu_clk;

    int checks = 0;
    int errors = 0;

    // Schedule model: a transfer granted at edge g with access length len
    // occupies the bus until edge g+1+len, where done is reported.
    int         k;
    bit         busy;
    int         g, endk, free_k;
    bit         own, last;
    bit         aw;
    logic [7:0] aa, ad;
    int         awt;
    int         cw[2];
    bit         gr[2];
    bit         e_psel, e_pen, e_pwrite;
    logic [7:0] e_paddr, e_pwdata;
    bit         e_ready[2], e_done[2], e_err[2];
    logic [7:0] e_rdata[2];
    bit         rnd;
    logic [7:0] d_prdata;
    bit         d_slverr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, k);
        end
    endtask

    task automatic model_reset();
        busy = 0; last = 1; free_k = 0; g = 0; endk = 0;
        e_psel = 0; e_pen = 0; e_pwrite = 0; e_paddr = 0; e_pwdata = 0;
        for (int p = 0; p < 2; p++) begin
            e_ready[p] = 0; e_done[p] = 0; e_err[p] = 0; e_rdata[p] = 0; gr[p] = 0;
        end
    endtask

    task automatic model_edge();
        bit v0, v1, o;
        v0 = req0_valid;
        v1 = req1_valid;
        for (int p = 0; p < 2; p++) begin
            gr[p] = 0; e_ready[p] = 0; e_done[p] = 0;
        end
        if (busy && k == endk) begin
            e_done[own] = 1;
            if (awt < TO) begin
                e_err[own] = pslverr;
                if (!aw) e_rdata[own] = prdata;
            end else begin
                e_err[own] = 1;
                e_rdata[own] = 8'h00;
            end
            busy = 0; last = own; free_k = k + 1;
        end else if (!busy && k >= free_k && (v0 || v1)) begin
            o = (v0 && v1) ? !last : !v0;
            busy = 1; g = k; own = o;
            aw  = o ? req1_write : req0_write;
            aa  = o ? req1_addr  : req0_addr;
            ad  = o ? req1_wdata : req0_wdata;
            awt = cw[o];
            endk = g + 1 + ((awt < TO) ? awt + 1 : TO);
            e_ready[o] = 1; gr[o] = 1; e_paddr = aa;
        end
        e_psel   = busy;
        e_pen    = busy && k > g;
        e_pwrite = busy && aw;
        e_pwdata = (busy && aw) ? ad : 8'h00;
    endtask

    task automatic compare();
        chk("psel", psel, e_psel);
        chk("penable", penable, e_pen);
        chk("pwrite", pwrite, e_pwrite);
        chk("paddr", paddr, e_paddr);
        chk("pwdata", pwdata, e_pwdata);
        chk("ready0", req0_ready, e_ready[0]);
        chk("ready1", req1_ready, e_ready[1]);
        chk("done0", req0_done, e_done[0]);
        chk("done1", req1_done, e_done[1]);
        chk("rdata0", req0_rdata, e_rdata[0]);
        chk("rdata1", req1_rdata, e_rdata[1]);
        if (e_done[0]) chk("err0", req0_err, e_err[0]);
        if (e_done[1]) chk("err1", req1_err, e_err[1]);
    endtask

    task automatic drive_slave();
        if (busy && k > g) pready = (awt < TO) && (k - g - 1 == awt);
        else pready = 1'($urandom_range(0, 1));
        prdata  = rnd ? 8'($urandom) : d_prdata;
        pslverr = rnd ? 1'($urandom_range(0, 1)) : d_slverr;
    endtask

    task automatic step();
        @(posedge cpu_clk);
        k++;
        model_edge();
        @(negedge cpu_clk);
        compare();
        if (gr[0]) req0_valid = 1'b0;
        if (gr[1]) req1_valid = 1'b0;
        drive_slave();
    endtask

    task automatic set_cmd(input int p, input bit w, input logic [7:0] a,
                           input logic [7:0] d, input int wt);
        cw[p] = wt;
        if (p == 0) begin
            req0_valid = 1'b1; req0_write = w; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = 1'b1; req1_write = w; req1_addr = a; req1_wdata = d;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (!busy && !req0_valid && !req1_valid) break;
            step();
        end
        step();
    endtask

    task automatic wait_done(input int p, input string nm);
        bit seen;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if ((p == 0 && req0_done) || (p == 1 && req1_done)) begin
                seen = 1;
                break;
            end
        end
        chk(nm, seen, 1);
    endtask

    int n;
    bit seen;
    int left0, left1;
    int order[$];
    int gedge[$];
    int wt;

    initial begin
        cpu_rst = 1'b1;
        req0_valid = 0; req0_write = 0; req0_addr = 0; req0_wdata = 0;
        req1_valid = 0; req1_write = 0; req1_addr = 0; req1_wdata = 0;
        prdata = 0; pready = 0; pslverr = 0;
        rnd = 0; d_prdata = 0; d_slverr = 0; k = 0;
        cw[0] = 0; cw[1] = 0;
        model_reset();
        repeat (2) @(negedge cpu_clk);
        chk("rst_psel", psel, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_ready0", req0_ready, 0);
        chk("rst_rdata1", req1_rdata, 0);
        cpu_rst = 1'b0;
        drive_slave();

        // Port 0 write, zero wait
        set_cmd(0, 1, 8'h02, 8'h5A, 0);
        step();
        chk("t1_ready0", req0_ready, 1);
        chk("t1_psel", psel, 1);
        chk("t1_paddr", paddr, 8'h02);
        chk("t1_pwdata", pwdata, 8'h5A);
        chk("t1_pen0", penable, 0);
        step();
        chk("t1_pen1", penable, 1);
        chk("t1_psel2", psel, 1);
        step();
        chk("t1_done0", req0_done, 1);
        chk("t1_err0", req0_err, 0);
        chk("t1_pwdata0", pwdata, 0);
        chk("t1_pselx", psel, 0);
        drain();

        // Port 1 read, two wait states
        d_prdata = 8'hA7;
        set_cmd(1, 0, 8'h01, 8'h00, 2);
        n = 0; seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (req1_done) begin seen = 1; break; end
            if (penable) n++;
        end
        chk("t2_done", seen, 1);
        chk("t2_access", n, 3);
        chk("t2_rdata1", req1_rdata, 8'hA7);
        chk("t2_err1", req1_err, 0);
        drain();

        // Both ports requesting continuously
        set_cmd(0, 1, 8'h10, 8'h01, 0);
        set_cmd(1, 1, 8'h11, 8'h02, 0);
        left0 = 3; left1 = 3;
        for (int i = 0; i < 60 && order.size() < 8; i++) begin
            step();
            if (req0_ready) begin order.push_back(0); gedge.push_back(k); end
            if (req1_ready) begin order.push_back(1); gedge.push_back(k); end
            if (gr[0] && left0 > 0) begin left0--; set_cmd(0, 1, 8'(20 + left0), 8'h33, 0); end
            if (gr[1] && left1 > 0) begin left1--; set_cmd(1, 0, 8'(30 + left1), 8'h00, 0); end
        end
        chk("t3_count", order.size(), 8);
        for (int i = 0; i < order.size(); i++) begin
            chk("t3_order", order[i], i % 2);
            if (i > 0) chk("t3_spacing", gedge[i] - gedge[i-1], 3);
        end
        drain();

        // Slave error on a read
        d_prdata = 8'h3C; d_slverr = 1;
        set_cmd(0, 0, 8'h03, 8'h00, 0);
        wait_done(0, "t4_done");
        chk("t4_err0", req0_err, 1);
        chk("t4_rdata0", req0_rdata, 8'h3C);
        d_slverr = 0;
        drain();

        // Timeout, then a normal transfer
        d_prdata = 8'hFF;
        set_cmd(0, 0, 8'h10, 8'h00, 9);
        n = 0; seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (req0_done) begin seen = 1; break; end
            if (penable) n++;
        end
        chk("t5_done", seen, 1);
        chk("t5_pen_cycles", n, 4);
        chk("t5_err0", req0_err, 1);
        chk("t5_rdata0", req0_rdata, 8'h00);
        set_cmd(1, 1, 8'h20, 8'h33, 0);
        wait_done(1, "t5_next_done");
        chk("t5_next_err", req1_err, 0);
        drain();

        // Reset during ACCESS
        set_cmd(0, 0, 8'h04, 8'h00, 9);
        repeat (3) step();
        chk("t6_in_access", penable, 1);
        cpu_rst = 1'b1;
        #1;
        chk("t6_psel", psel, 0);
        chk("t6_pen", penable, 0);
        chk("t6_rdata1", req1_rdata, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge cpu_clk);
            k++;
            chk("t6_nodone", req0_done, 0);
            chk("t6_noready", req0_ready, 0);
        end
        cpu_rst = 1'b0;
        model_reset();
        set_cmd(0, 0, 8'h05, 8'h00, 0);
        set_cmd(1, 0, 8'h06, 8'h00, 0);
        step();
        chk("t6_tie0", req0_ready, 1);
        chk("t6_tie1", req1_ready, 0);
        drain();

        // Random traffic
        rnd = 1;
        for (int i = 0; i < 3000; i++) begin
            step();
            chk("ready_excl", req0_ready & req1_ready, 0);
            chk("done_excl", req0_done & req1_done, 0);
            for (int p = 0; p < 2; p++) begin
                if (((p == 0) ? req0_valid : req1_valid) == 1'b0 &&
                    $urandom_range(0, 2) == 0) begin
                    wt = $urandom_range(0, 7);
                    if (wt > 5) wt = 0;
                    set_cmd(p, 1'($urandom_range(0, 1)), 8'($urandom),
                            8'($urandom), wt);
                end
            end
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_arbiter.md
# apb_arbiter

Two-port APB master arbiter for the 8-bit timer subsystem. It accepts read/write commands from two independent requesters, such as the CPU path and a test/configuration sequencer. It grants them round-robin and runs each command as a single APB3 transfer (setup, access, wait on `pready`) on the shared bus to the timer register slave. It returns read data and error status per requester, and aborts transfers whose slave never responds.

## Interface
- `TIMEOUT`, default 16: maximum ACCESS cycles with `pready` low before abort; legal range 1..255.
- `cpu_clk` input 1: single clock, all logic on rising edge.
- `cpu_rst` input 1: asynchronous, active-high reset.
- `reqN_valid` input 1 (N=0,1): command pending; held with fields stable until `reqN_ready`.
- `reqN_write` input 1: 1 = write, 0 = read.
- `reqN_addr` input 8: register address.
- `reqN_wdata` input 8: write data; ignored for reads.
- `reqN_ready` output 1: one-cycle pulse, command accepted.
- `reqN_done` output 1: one-cycle pulse, transfer finished.
- `reqN_rdata` output 8: read data; valid while `reqN_done`=1, held until the next done for that port.
- `reqN_err` output 1: valid with `reqN_done`; set for slave error or timeout.
- `psel`, `penable`, `pwrite` output 1: APB control.
- `paddr`, `pwdata` output 8: APB address and write data.
- `prdata` input 8: APB read data.
- `pready`, `pslverr` input 1: APB slave response.

## Operation
- FSM states are IDLE, SETUP and ACCESS. All outputs are registered.
- **IDLE**
  - No `reqN_valid`: remain in IDLE.
  - Only one requester valid: grant it.
  - Both valid: grant the port that is not `last_grant`.
  - On grant, the next edge does all of the following: latch write, addr and wdata; drive `psel`=1, `penable`=0, `pwrite`, `paddr`; drive `pwdata` (forced to 0 for reads); pulse the granted `reqN_ready`; go to SETUP.
- **SETUP**: the next edge sets `penable`=1, clears the timeout counter and goes to ACCESS.
- **ACCESS** with `pready`=1:
  - Next edge drives `psel`=0, `penable`=0, `pwrite`=0, `pwdata`=0.
  - It pulses `reqN_done` for the owner and drives `reqN_err`=`pslverr`.
  - For reads it loads `reqN_rdata`=`prdata`; for writes `reqN_rdata` is unchanged.
  - It updates `last_grant` to the owner and goes to IDLE.
- **ACCESS** with `pready`=0:
  - If cnt < TIMEOUT-1: cnt increments and the state stays ACCESS.
  - If cnt == TIMEOUT-1: abort. Bus signals are deasserted as for completion, `reqN_done`=1, `reqN_err`=1, `reqN_rdata`=0, `last_grant` updates, next state is IDLE.
- If `pready` is high on the abort cycle, completion takes priority.
- `paddr` holds its last value after a transfer. All other bus outputs return to 0.
- `reqN_ready` and `reqN_done` never assert for both ports in the same cycle.
- The non-granted requester keeps its `valid` asserted and is served next.
- `valid` is not sampled outside IDLE. A requester may change its command any time after it sees `ready`.
- Timeout counter is 8 bits and only counts in ACCESS.

## Timing
- Reset values: all outputs 0, state IDLE, `last_grant`=1 so port 0 wins the first tie, counter 0.
- Reset mid-transfer forces reset values immediately. No `done` is issued for the aborted command.
- Zero-wait transfer, with the edge where IDLE sees `valid` as E0:
  - E1: `psel`=1, `ready` pulse.
  - E2: `penable`=1.
  - E3: bus idle, `done` pulse.
- Each wait state adds one cycle between E2 and E3.
- Minimum one IDLE cycle with `psel`=0 between transfers, so back-to-back zero-wait throughput is one transfer per 3 cycles.
- Latency from `valid` to `done` is 3 + wait cycles; maximum 2 + TIMEOUT cycles.

## Test plan
- **Port 0 write, zero wait.** Port 0 writes 0x5A to 0x02 with `pready` tied 1. Required: `psel` high 2 cycles with `paddr`=0x02 and `pwdata`=0x5A; `penable` high on the 2nd; `req0_done`=1 with `req0_err`=0 3 cycles after acceptance; `pwdata` back to 0.
- **Port 1 read, 2 wait states.** Port 1 reads 0x01, slave returns 0xA7 after 2 wait states. Required: ACCESS lasts 3 cycles; `req1_rdata`=0xA7 and `req1_err`=0 with `req1_done`.
- **Simultaneous requests.** Both ports request continuously, 4 transfers each, zero wait. Required: grants in order 0,1,0,1,…; no overlapping `ready`/`done`; `psel` low exactly 1 cycle between transfers.
- **Slave error.** Read 0x03 with `pslverr`=1 at completion. Required: `req0_done` with `req0_err`=1 and `req0_rdata`=`prdata`.
- **Timeout.** TIMEOUT=4, `pready` held 0. Required: `penable` high exactly 4 cycles, then `done` with `err`=1 and `rdata`=0; the next request proceeds normally.
- **Reset mid-transfer.** Assert `cpu_rst` during ACCESS. Required: `psel`, `penable` and all pulses drop without waiting for a clock edge, no `done` is issued, and after release port 0 wins a tie.
